// File: rtl/writeback_regfile_pkg.sv
// Shared pipeline constants and the writeback result-select encoding.
package writeback_regfile_pkg;

   localparam int XLEN   = 32;
   localparam int ADDR_W = 5;
   localparam int NREGS  = 32;

   // ResultSrc encodings used by the writeback mux
   typedef enum logic [1:0] {
      RES_ALU = 2'b00,
      RES_MEM = 2'b01,
      RES_PC4 = 2'b10,
      RES_IMM = 2'b11
   } result_src_e;

endpackage

// File: rtl/writeback_regfile_register_file.sv
// Architectural register file: x1..x31 storage, x0 hardwired to zero,
// synchronous active-high reset, and a write-to-read bypass so Decode sees a
// same-cycle write without needing a half-cycle write scheme.
import writeback_regfile_pkg::*;

module register_file #(
   parameter int XLEN   = writeback_regfile_pkg::XLEN,
   parameter int ADDR_W = writeback_regfile_pkg::ADDR_W,
   parameter int NREGS  = writeback_regfile_pkg::NREGS
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] wa_i,
   input  logic [XLEN-1:0]   wd_i,
   input  logic [ADDR_W-1:0] a1_i,
   input  logic [ADDR_W-1:0] a2_i,
   output logic [XLEN-1:0]   rd1_o,
   output logic [XLEN-1:0]   rd2_o
);

   // x0 has no storage; entries start at index 1
   logic [XLEN-1:0] regs_q [1:NREGS-1];
   logic [XLEN-1:0] regs_d [1:NREGS-1];

   // A write is effective only out of reset and never to x0; reset wins
   logic wr_en;
   assign wr_en = we_i && !rst && (wa_i != '0);

   // Next-state: update the addressed register when a write is effective
   always_comb begin
      regs_d = regs_q;
      if (wr_en) begin
         regs_d[wa_i] = wd_i;
      end
   end

   // Storage update; reset clears x1..x31 and drops any concurrent write
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 1; i < NREGS; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         regs_q <= regs_d;
      end
   end

   // Read port 1: x0 reads zero, matching in-flight write bypasses storage
   always_comb begin
      rd1_o = '0;
      if (a1_i != '0) begin
         if (wr_en && (wa_i == a1_i)) begin
            rd1_o = wd_i;
         end else begin
            rd1_o = regs_q[a1_i];
         end
      end
   end

   // Read port 2: same rules as port 1, bypass decided independently
   always_comb begin
      rd2_o = '0;
      if (a2_i != '0) begin
         if (wr_en && (wa_i == a2_i)) begin
            rd2_o = wd_i;
         end else begin
            rd2_o = regs_q[a2_i];
         end
      end
   end

endmodule

// File: rtl/writeback_regfile.sv
// Writeback stage: selects the W-stage result and commits it to the register
// file, which also serves the Decode stage's two read ports.
import writeback_regfile_pkg::*;

module writeback_regfile #(
   parameter int XLEN   = writeback_regfile_pkg::XLEN,
   parameter int ADDR_W = writeback_regfile_pkg::ADDR_W,
   parameter int NREGS  = writeback_regfile_pkg::NREGS
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              RegWriteW,
   input  logic [1:0]        ResultSrcW,
   input  logic [XLEN-1:0]   ALUResultW,
   input  logic [XLEN-1:0]   ReadDataW,
   input  logic [XLEN-1:0]   PCPlus4W,
   input  logic [XLEN-1:0]   ImmExtW,
   input  logic [ADDR_W-1:0] RdW,
   input  logic [ADDR_W-1:0] A1D,
   input  logic [ADDR_W-1:0] A2D,
   output logic [XLEN-1:0]   RD1D,
   output logic [XLEN-1:0]   RD2D,
   output logic [XLEN-1:0]   ResultW
);

   // Zero-latency result select; follows its inputs, including during reset
   always_comb begin
      ResultW = ALUResultW;
      case (ResultSrcW)
         RES_ALU: ResultW = ALUResultW;
         RES_MEM: ResultW = ReadDataW;
         RES_PC4: ResultW = PCPlus4W;
         RES_IMM: ResultW = ImmExtW;
         default: ResultW = ALUResultW;
      endcase
   end

   register_file #(
      .XLEN   (XLEN),
      .ADDR_W (ADDR_W),
      .NREGS  (NREGS)
   ) u_register_file (
      .clk   (clk),
      .rst   (rst),
      .we_i  (RegWriteW),
      .wa_i  (RdW),
      .wd_i  (ResultW),
      .a1_i  (A1D),
      .a2_i  (A2D),
      .rd1_o (RD1D),
      .rd2_o (RD2D)
   );

endmodule
